// File: rtl/ch2_pkg.sv
// ============================================================================
// ch2_pkg : shared constants and helpers for the chapter-2 datapath.
// Rev 1.0
// ============================================================================
`default_nettype none

package ch2_pkg;

  localparam int DEMUX_DATA_W = 1;
  localparam int DEMUX_SEL_W  = 3;

  // Number of lanes addressed by a select of the given width.
  function automatic int lanes(input int sel_w);
    return 1 << sel_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_onehot_dec.sv
// ============================================================================
// demux_onehot_dec : combinational binary-to-one-hot decoder (SEL_W -> 2**SEL_W).
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_onehot_dec
  import ch2_pkg::*;
#(
  parameter int SEL_W = DEMUX_SEL_W,
  parameter int N     = lanes(SEL_W)
) (
  input  logic [SEL_W-1:0] S,
  output logic [N-1:0]     onehot
);

  always_comb begin
    onehot    = '0;
    onehot[S] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/demux_1to8_reg.sv
// ============================================================================
// demux_1to8_reg : registered 1-to-N demultiplexer; lane S takes I, others 0.
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_1to8_reg
  import ch2_pkg::*;
#(
  parameter int DATA_W = DEMUX_DATA_W,
  parameter int SEL_W  = DEMUX_SEL_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_W-1:0]              I,
  input  logic [SEL_W-1:0]               S,
  input  logic                           en,
  output logic [DATA_W*lanes(SEL_W)-1:0] O
);

  localparam int c_n = lanes(SEL_W);

  logic [c_n-1:0]        w_onehot;
  logic [DATA_W*c_n-1:0] w_lanes;
  logic [DATA_W*c_n-1:0] r_o;

  demux_onehot_dec #(
    .SEL_W (SEL_W),
    .N     (c_n)
  ) u_dec (
    .S      (S),
    .onehot (w_onehot)
  );

  // Each lane is I gated by its decoder bit, so unselected lanes are 0.
  for (genvar k = 0; k < c_n; k++) begin : g_lane
    assign w_lanes[k*DATA_W +: DATA_W] = I & {DATA_W{w_onehot[k]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_o <= '0;
    end else if (en) begin
      r_o <= w_lanes;
    end
  end

  assign O = r_o;

endmodule

`default_nettype wire

// File: tb/tb_demux_1to8_reg.sv
// ============================================================================
// tb_demux_1to8_reg : scoreboard bench for the default (1x8) and 4x4 demux.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_demux_1to8_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, I;
  logic [2:0]  S;
  logic [7:0]  O;
  logic        en2;
  logic [3:0]  I2;
  logic [1:0]  S2;
  logic [15:0] O2;

  demux_1to8_reg dut (
    .clk (clk), .rst (rst), .I (I), .S (S), .en (en), .O (O)
  );

  demux_1to8_reg #(.DATA_W(4), .SEL_W(2)) dut2 (
    .clk (clk), .rst (rst), .I (I2), .S (S2), .en (en2), .O (O2)
  );

  logic [7:0]  q1[$];
  logic [15:0] q2[$];
  logic [7:0]  m1;
  logic [15:0] m2;
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what each output must show after the edge.
  task automatic step(input logic r, input logic e, input logic d, input logic [2:0] s,
                      input logic e2, input logic [3:0] d2, input logic [1:0] s2);
    @(negedge clk);
    rst = r; en = e; I = d; S = s; en2 = e2; I2 = d2; S2 = s2;
    if (r) begin
      m1 = '0;
      m2 = '0;
    end else begin
      if (e)  m1 = 8'(d) << s;
      if (e2) m2 = 16'(d2) << (32'(s2) * 4);
    end
    q1.push_back(m1);
    q2.push_back(m2);
  endtask

  // Monitor: every registered output is compared against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (q1.size() > 0) begin
      logic [7:0] e8;
      e8 = q1.pop_front();
      chk("o8", 16'(O), 16'(e8));
      chk("o8_at_most_one_lane", 16'($countones(O) <= 1), 16'd1);
    end
    if (q2.size() > 0) begin
      logic [15:0] e16;
      int nz;
      e16 = q2.pop_front();
      chk("o16", O2, e16);
      nz = 0;
      for (int k = 0; k < 4; k++) if (O2[k*4 +: 4] != 4'h0) nz++;
      chk("o16_at_most_one_lane", 16'(nz <= 1), 16'd1);
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b0 && en === 1'b1)
      assert (!$isunknown(S)) else $error("select unknown while enabled");
  end

  initial begin
    int wait_n;
    rst = 1'b1; en = 1'b0; I = 1'b0; S = '0;
    en2 = 1'b0; I2 = '0; S2 = '0;
    m1 = '0; m2 = '0;

    // Reset held with enable asserted, then first load.
    step(1, 1, 1, 3'd5, 1, 4'hA, 2'd3);
    step(1, 1, 1, 3'd5, 1, 4'hA, 2'd3);
    step(0, 1, 1, 3'd5, 1, 4'h5, 2'd1);

    // Select sweep.
    for (int s = 0; s < 8; s++)
      step(0, 1, 1, 3'(s), 1, 4'($urandom), 2'($urandom));

    // Data toggle on lane 2.
    for (int k = 0; k < 4; k++)
      step(0, 1, 1'(~k[0]), 3'd2, 0, 4'hF, 2'd0);

    // Enable hold.
    step(0, 1, 1, 3'd6, 0, 4'h0, 2'd0);
    repeat (3) step(0, 0, 1, 3'd1, 0, 4'h0, 2'd0);
    step(0, 1, 1, 3'd1, 0, 4'h0, 2'd0);

    // Mid-stream reset.
    step(0, 1, 1, 3'd7, 1, 4'h3, 2'd2);
    step(1, 1, 1, 3'd7, 1, 4'h3, 2'd2);
    step(0, 1, 1, 3'd7, 1, 4'h3, 2'd2);

    // Wider variant: lane 3 then lane 0 with data A.
    step(0, 0, 0, 3'd0, 1, 4'hA, 2'd3);
    step(0, 0, 0, 3'd0, 1, 4'hA, 2'd0);
    step(0, 0, 0, 3'd0, 0, 4'h5, 2'd2);

    // Random traffic with occasional reset.
    for (int n = 0; n < 300; n++)
      step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 3'($urandom),
           1'($urandom), 4'($urandom), 2'($urandom));

    @(negedge clk);
    en = 1'b0; en2 = 1'b0; rst = 1'b0;
    wait_n = 0;
    while ((q1.size() > 0 || q2.size() > 0) && wait_n < 10) begin
      @(posedge clk);
      wait_n++;
    end
    #2;
    if (q1.size() > 0 || q2.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d entries left, required 0", q1.size(), q2.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
